axis_stream_sink: RTL
=====================

Name: axis_stream_sink

Overview:
AXI4-Stream slave that accepts one frame of up to NUMBER_OF_INPUT_WORDS words from the stream master and buffers them in an internal memory. It checks each frame against the master's fixed pattern: an incrementing payload 1..N, full strobes, and TLAST on word N. Once capture ends, the block drains the words through a simple pop-style read port and then re-arms for the next frame. It sits on the receive side of the stream link and is the self-checking sink used with the stream generator.

Parameters:
C_S_AXIS_TDATA_WIDTH, 32, stream data width in bits; multiple of 8.
NUMBER_OF_INPUT_WORDS, 8, buffer depth and expected frame length in words; must be at least 2.

Ports:
S_AXIS_ACLK  in  1  clock; all logic on the rising edge.
S_AXIS_ARESETN  in  1  reset, asynchronous, active-low.
S_AXIS_TREADY  out  1  sink ready.
S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  stream payload.
S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  byte strobes.
S_AXIS_TLAST  in  1  last word of frame.
S_AXIS_TVALID  in  1  master valid.
rd_en  in  1  pop request.
rd_data  out  C_S_AXIS_TDATA_WIDTH  popped word, registered.
rd_valid  out  1  one-cycle pulse qualifying rd_data.
frame_done  out  1  high while a captured frame is awaiting drain.
frame_err  out  3  sticky per-frame errors: [0] data mismatch, [1] length/TLAST mismatch, [2] strobe not all-ones.
word_count  out  $clog2(NUMBER_OF_INPUT_WORDS+1)  number of words captured in the current or last frame.

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE; wr_ptr, rd_ptr and word_count = 0; S_AXIS_TREADY = 0; rd_data = 0; rd_valid = 0; frame_done = 0; frame_err = 0. Reset mid-frame abandons the frame, and all buffered data becomes invalid.
- States: IDLE, WRITE_FIFO, DRAIN.
- IDLE:
  - S_AXIS_TREADY = 0.
  - If S_AXIS_TVALID = 1, go to WRITE_FIFO next cycle and clear frame_err and word_count on that transition.
  - No beat is accepted in IDLE, so the first acceptance is at least 1 cycle after TVALID rises.
- WRITE_FIFO:
  - S_AXIS_TREADY = 1, combinational from state; deasserts in the same cycle the state leaves WRITE_FIFO.
  - A beat is accepted when TVALID and TREADY are both high:
    - mem[wr_ptr] <= TDATA; wr_ptr and word_count increment.
    - Data check: compare TDATA against wr_ptr+1, zero-extended to the data width. On mismatch, set frame_err[0].
    - Strobe check: if TSTRB is not all-ones, set frame_err[2].
  - Frame end is the earlier of two events:
    - TLAST accepted.
    - The NUMBER_OF_INPUT_WORDS-th word accepted.
  - Length check, set frame_err[1] if either:
    - TLAST is accepted at index < N-1.
    - Word N-1 is accepted with TLAST = 0.
  - On frame end, go to DRAIN next cycle and set frame_done = 1.
  - TVALID dropping mid-frame is legal; the block waits indefinitely.
- DRAIN:
  - S_AXIS_TREADY = 0.
  - If rd_en = 1 and rd_ptr < word_count: rd_data <= mem[rd_ptr], rd_valid = 1 on the next cycle (1-cycle latency), and rd_ptr increments.
  - rd_en with no data remaining is ignored; rd_valid stays 0.
  - Once the last word has been popped (rd_ptr == word_count), go to IDLE next cycle. On that transition, frame_done = 0 and wr_ptr and rd_ptr clear.
  - word_count and frame_err hold until the next IDLE→WRITE_FIFO transition.
- rd_en outside DRAIN is ignored.
- Pointer widths are $clog2(NUMBER_OF_INPUT_WORDS+1) bits. Pointers never wrap, because a frame is capped at N words.

Test Plan:
1. Reset, then master sends 1..8 with TLAST on word 8 and TREADY not stalled → 8 accepts; frame_done=1; word_count=8; frame_err=3'b000. Then 8 back-to-back rd_en → rd_data 1,2,…,8 each with rd_valid, one cycle after each rd_en; then frame_done=0 and state IDLE.
2. Master pulls TVALID low for 3 cycles between words 4 and 5 → no beat is lost; word_count=8; frame_err=0.
3. Early TLAST on word 5 (data 1..5) → capture ends; word_count=5; frame_err=3'b010; drain returns 1..5; a 6th rd_en gives no rd_valid.
4. Word 3 sent as 0x0000_0007 → frame_err[0]=1; rd_data for the 3rd pop = 0x0000_0007. Also TSTRB=4'b0111 on word 6 → frame_err[2]=1.
5. Word 8 sent without TLAST → frame_err[1]=1; TREADY drops after the 8th accept; extra master beats are not accepted.
6. Assert S_AXIS_ARESETN low for 1 cycle after word 4 → all outputs return to reset values immediately. The next frame 1..8 is captured cleanly with frame_err=0.

Source files
------------

// File: rtl/axis_stream_sink.sv
// AXI4-Stream single-frame sink: captures up to NUMBER_OF_INPUT_WORDS words,
// checks them against the generator's 1..N pattern and drains them through a pop port.
module axis_stream_sink #(
    parameter int C_S_AXIS_TDATA_WIDTH  = 32,
    parameter int NUMBER_OF_INPUT_WORDS = 8
) (
    input  logic                                       S_AXIS_ACLK,
    input  logic                                       S_AXIS_ARESETN,
    output logic                                       S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]            S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]          S_AXIS_TSTRB,
    input  logic                                       S_AXIS_TLAST,
    input  logic                                       S_AXIS_TVALID,
    input  logic                                       rd_en,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]            rd_data,
    output logic                                       rd_valid,
    output logic                                       frame_done,
    output logic [2:0]                                 frame_err,
    output logic [$clog2(NUMBER_OF_INPUT_WORDS+1)-1:0] word_count
);

    localparam int DW = C_S_AXIS_TDATA_WIDTH;
    localparam int SW = C_S_AXIS_TDATA_WIDTH / 8;
    localparam int PW = $clog2(NUMBER_OF_INPUT_WORDS + 1);
    localparam int AW = $clog2(NUMBER_OF_INPUT_WORDS);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUMBER_OF_INPUT_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_FIFO = 2'd1,
        DRAIN      = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;

    logic [DW-1:0] mem_r [0:NUMBER_OF_INPUT_WORDS-1];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] word_count_r;
    logic [DW-1:0] rd_data_r;
    logic          rd_valid_r;
    logic          frame_done_r;
    logic [2:0]    frame_err_r;

    logic          tready_s;
    logic          start_s;
    logic          accept_s;
    logic          frame_end_s;
    logic          pop_s;
    logic          finish_s;
    logic [DW-1:0] exp_data_s;
    logic [2:0]    err_set_s;

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nxt_s = state_r;
        tready_s    = 1'b0;
        start_s     = 1'b0;
        accept_s    = 1'b0;
        frame_end_s = 1'b0;
        pop_s       = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (S_AXIS_TVALID) begin
                    start_s     = 1'b1;
                    state_nxt_s = WRITE_FIFO;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITE_FIFO: begin
                tready_s = 1'b1;
                accept_s = S_AXIS_TVALID;
                // A frame ends on TLAST or when the buffer is full, whichever comes first
                if (accept_s && (S_AXIS_TLAST || (wr_ptr_r == LAST_IDX))) begin
                    frame_end_s = 1'b1;
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = WRITE_FIFO;
                end
            end
            DRAIN: begin
                if (rd_ptr_r == word_count_r) begin
                    finish_s    = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    pop_s       = rd_en;
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign exp_data_s   = DW'(wr_ptr_r) + DW'(1'b1);
    assign err_set_s[0] = accept_s && (S_AXIS_TDATA != exp_data_s);
    assign err_set_s[1] = accept_s && ((S_AXIS_TLAST && (wr_ptr_r < LAST_IDX)) ||
                                       (!S_AXIS_TLAST && (wr_ptr_r == LAST_IDX)));
    assign err_set_s[2] = accept_s && (S_AXIS_TSTRB != {SW{1'b1}});

    // State register
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pointers, status and read-port registers
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            word_count_r <= {PW{1'b0}};
            rd_data_r    <= {DW{1'b0}};
            rd_valid_r   <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 3'b000;
        end else begin
            rd_valid_r <= 1'b0;
            if (start_s) begin
                word_count_r <= {PW{1'b0}};
                frame_err_r  <= 3'b000;
            end else if (accept_s) begin
                wr_ptr_r     <= wr_ptr_r + PW'(1'b1);
                word_count_r <= word_count_r + PW'(1'b1);
                frame_err_r  <= frame_err_r | err_set_s;
            end
            if (frame_end_s) begin
                frame_done_r <= 1'b1;
            end
            if (pop_s) begin
                rd_data_r  <= mem_r[rd_ptr_r[AW-1:0]];
                rd_valid_r <= 1'b1;
                rd_ptr_r   <= rd_ptr_r + PW'(1'b1);
            end
            if (finish_s) begin
                frame_done_r <= 1'b0;
                wr_ptr_r     <= {PW{1'b0}};
                rd_ptr_r     <= {PW{1'b0}};
            end
        end
    end

    // Frame buffer; contents are only meaningful below word_count, so no reset
    always_ff @(posedge S_AXIS_ACLK) begin
        if (accept_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= S_AXIS_TDATA;
        end
    end

    assign S_AXIS_TREADY = tready_s;
    assign rd_data       = rd_data_r;
    assign rd_valid      = rd_valid_r;
    assign frame_done    = frame_done_r;
    assign frame_err     = frame_err_r;
    assign word_count    = word_count_r;

endmodule
